// File: rtl/sipo_buf_param_if.sv
// sipo_buf_param_if
// Host-side bus of the scan capture buffer: op handshake, serial scan
// input, read data and fill status. The host drives through the master
// modport and the buffer answers through the slave modport.
interface sipo_buf_param_if #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 6
);
    logic              val_op;
    logic [1:0]        op;
    logic              op_ack;
    logic              op_commit;
    logic              op_err;
    logic              sdi;
    logic              scaning;
    logic [WORD_W-1:0] rdata;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;

    modport master (
        output val_op, op, sdi,
        input  op_ack, op_commit, op_err, scaning, rdata, full, empty, count
    );

    modport slave (
        input  val_op, op, sdi,
        output op_ack, op_commit, op_err, scaning, rdata, full, empty, count
    );
endinterface

// File: rtl/sipo_buf_param.sv
// sipo_buf_param
// Serial-in/parallel-out scan capture buffer with its controller.
// A WR op shifts WORD_W scan bits (MSB first) into a word and pushes it into
// a DEPTH-entry circular memory; RD pops the oldest word; CLR empties the
// buffer. Each op answers with op_ack and op_commit pulses, plus op_err
// when the op was rejected (WR while full, RD while empty, reserved code).
//
// Optional feature, macro SIPO_BUF_PARITY_EN: the scan stream carries one
// extra even-parity bit after the word; a word failing the check is dropped
// and the WR completes with op_err.
module sipo_buf_param #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset_n,
    sipo_buf_param_if.slave    bus
);

    // ------------------------------------------------------------------
    // Local types and constants
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        OP_WR  = 2'b00,
        OP_RD  = 2'b01,
        OP_CLR = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEIN  = 3'd1,
        MEMW  = 3'd2,
        MEMR  = 3'd3,
        MEMRR = 3'd4,
        DONE1 = 3'd5
    } state_e;

`ifdef SIPO_BUF_PARITY_EN
    localparam int SEIN_LEN = WORD_W + 1;
`else
    localparam int SEIN_LEN = WORD_W;
`endif

    localparam int              CNT_W    = $clog2(SEIN_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SEIN_LEN - 1);
    localparam logic [ADDR_W:0] DEPTH_M1 = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e              state_q, state_d;
    logic                is_clr_q, is_clr_d;   // DONE1 reason: clear vs error
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [WORD_W-1:0]   shreg_q;
    logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]     count_q;
    logic                full_q, empty_q;
    logic [WORD_W-1:0]   rdata_q;
    logic [WORD_W-1:0]   mem [DEPTH];

    op_e                 op_in;
    logic                par_fail;
    logic                mem_we;
    logic                rd_en;
    logic                pop;
    logic                do_clr;
    logic                op_ack, op_commit, op_err, scaning;

    assign op_in = op_e'(bus.op);

`ifdef SIPO_BUF_PARITY_EN
    logic par_q;
    // Even parity over the captured word plus its parity bit must be zero.
    assign par_fail = (^shreg_q) ^ par_q;
`else
    assign par_fail = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Controller: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            is_clr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_clr_q <= is_clr_d;
        end
    end

    // Controller: next-state decode and per-state response pulses.
    // NOTE: every output of this block is assigned a default first, so no
    // path through the case leaves a value unassigned and no latch forms.
    always_comb begin
        state_d   = state_q;
        is_clr_d  = is_clr_q;
        op_ack    = 1'b0;
        op_commit = 1'b0;
        op_err    = 1'b0;
        scaning   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.val_op) begin
                    state_d  = DONE1;
                    is_clr_d = 1'b0;
                    case (op_in)
                        OP_WR:   if (!full_q)  state_d = SEIN;
                        OP_RD:   if (!empty_q) state_d = MEMR;
                        OP_CLR:  is_clr_d = 1'b1;
                        default: is_clr_d = 1'b0;
                    endcase
                end
            end
            SEIN: begin
                scaning = 1'b1;
                op_ack  = (bit_cnt_q == '0);
                if (bit_cnt_q == CNT_LAST) state_d = MEMW;
            end
            MEMW: begin
                op_commit = 1'b1;
                op_err    = par_fail;
                state_d   = IDLE;
            end
            MEMR: begin
                op_ack  = 1'b1;
                state_d = MEMRR;
            end
            MEMRR: begin
                op_commit = 1'b1;
                state_d   = IDLE;
            end
            DONE1: begin
                op_ack    = 1'b1;
                op_commit = 1'b1;
                op_err    = !is_clr_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_we = (state_q == MEMW) && !par_fail;
    assign rd_en  = (state_q == MEMR);
    assign pop    = (state_q == MEMRR);
    assign do_clr = (state_q == DONE1) && is_clr_q;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    // Bit counter and shift register: count scan cycles, shift MSB first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt_q <= '0;
            shreg_q   <= '0;
`ifdef SIPO_BUF_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else if (state_q == SEIN) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
`ifdef SIPO_BUF_PARITY_EN
            if (bit_cnt_q < CNT_W'(WORD_W)) shreg_q <= {shreg_q[WORD_W-2:0], bus.sdi};
            else                            par_q   <= bus.sdi;
`else
            shreg_q   <= {shreg_q[WORD_W-2:0], bus.sdi};
`endif
        end else begin
            bit_cnt_q <= '0;
        end
    end

    // Pointers, occupancy and registered status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else if (do_clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else if (mem_we) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            count_q  <= count_q + 1'b1;
            full_q   <= (count_q == DEPTH_M1);
            empty_q  <= 1'b0;
        end else if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q  <= count_q - 1'b1;
            full_q   <= 1'b0;
            empty_q  <= (count_q == CNT_ONE);
        end
    end

    // Storage array write port.
    // NOTE: the array has no reset; contents survive reset and only the
    // pointers/count decide what is valid, which keeps it mappable to RAM.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr_q] <= shreg_q;
    end

    // Synchronous read port; doubles as the held rdata register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   rdata_q <= '0;
        else if (rd_en) rdata_q <= mem[rd_ptr_q];
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.op_ack    = op_ack;
    assign bus.op_commit = op_commit;
    assign bus.op_err    = op_err;
    assign bus.scaning   = scaning;
    assign bus.rdata     = rdata_q;
    assign bus.full      = full_q;
    assign bus.empty     = empty_q;
    assign bus.count     = count_q;

endmodule

// File: tb/tb_sipo_buf_param.sv
// tb_sipo_buf_param
// Directed plus randomized bench for sipo_buf_param. A FIFO queue holds the
// words the buffer should contain; every response pulse, rdata and status
// value is compared against it at the negative clock edge.
// Build with SIPO_BUF_PARITY_EN defined to exercise the parity stream.
module tb_sipo_buf_param;

    localparam int WORD_W = 32;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = $clog2(DEPTH);

`ifdef SIPO_BUF_PARITY_EN
    localparam int NB     = WORD_W + 1;
    localparam bit PAR_EN = 1'b1;
`else
    localparam int NB     = WORD_W;
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    logic [WORD_W-1:0] model_q [$];

    sipo_buf_param_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();

    sipo_buf_param #(.WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, ".count"}, 64'(bus.count), 64'(model_q.size()));
        check({tag, ".empty"}, 64'(bus.empty), 64'(model_q.size() == 0));
        check({tag, ".full"},  64'(bus.full),  64'(model_q.size() == DEPTH));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".ack"},     64'(bus.op_ack),    64'd0);
        check({tag, ".commit"},  64'(bus.op_commit), 64'd0);
        check({tag, ".err"},     64'(bus.op_err),    64'd0);
        check({tag, ".scaning"}, 64'(bus.scaning),   64'd0);
        check({tag, ".rdata"},   64'(bus.rdata),     64'd0);
        check_status(tag);
    endtask

    // WR op: entered at a negedge in IDLE; par is the parity bit sent after
    // the word (only shifted when the parity build is active).
    task automatic do_wr(input logic [WORD_W-1:0] word, input logic par);
        logic [WORD_W:0] ext;
        logic [NB-1:0]   bits;
        logic            perr;
        bit              ok;
        ext  = {word, par};
        bits = ext[WORD_W -: NB];
        perr = PAR_EN && (^ext);
        ok   = model_q.size() < DEPTH;
        bus.val_op = 1'b1;
        bus.op     = 2'b00;
        @(negedge clk);
        check("wr.ack", 64'(bus.op_ack), 64'd1);
        bus.val_op = 1'b0;
        if (!ok) begin
            check("wr_full.commit",  64'(bus.op_commit), 64'd1);
            check("wr_full.err",     64'(bus.op_err),    64'd1);
            check("wr_full.scaning", 64'(bus.scaning),   64'd0);
            @(negedge clk);
            check_status("wr_full");
            return;
        end
        for (int i = 0; i < NB; i++) begin
            check("wr.scaning", 64'(bus.scaning),   64'd1);
            check("wr.commit0", 64'(bus.op_commit), 64'd0);
            if (i > 0) check("wr.ack_once", 64'(bus.op_ack), 64'd0);
            bus.sdi = bits[NB-1-i];
            @(negedge clk);
        end
        check("wr.commit",   64'(bus.op_commit), 64'd1);
        check("wr.err",      64'(bus.op_err),    64'(perr));
        check("wr.scan_end", 64'(bus.scaning),   64'd0);
        if (!perr) model_q.push_back(word);
        @(negedge clk);
        check("wr.commit_pulse", 64'(bus.op_commit), 64'd0);
        check_status("wr");
    endtask

    task automatic do_rd();
        logic [WORD_W-1:0] exp_word;
        bus.val_op = 1'b1;
        bus.op     = 2'b01;
        @(negedge clk);
        check("rd.ack", 64'(bus.op_ack), 64'd1);
        bus.val_op = 1'b0;
        if (model_q.size() == 0) begin
            check("rd_empty.commit", 64'(bus.op_commit), 64'd1);
            check("rd_empty.err",    64'(bus.op_err),    64'd1);
            @(negedge clk);
            check_status("rd_empty");
            return;
        end
        check("rd.commit0", 64'(bus.op_commit), 64'd0);
        @(negedge clk);
        exp_word = model_q.pop_front();
        check("rd.commit", 64'(bus.op_commit), 64'd1);
        check("rd.err",    64'(bus.op_err),    64'd0);
        check("rd.ack0",   64'(bus.op_ack),    64'd0);
        check("rd.rdata",  64'(bus.rdata),     64'(exp_word));
        @(negedge clk);
        check("rd.rdata_held", 64'(bus.rdata), 64'(exp_word));
        check_status("rd");
    endtask

    // CLR (2'b10) or reserved (2'b11): single-cycle DONE1 response.
    task automatic do_short(input logic [1:0] code);
        bus.val_op = 1'b1;
        bus.op     = code;
        @(negedge clk);
        bus.val_op = 1'b0;
        check("short.ack",    64'(bus.op_ack),    64'd1);
        check("short.commit", 64'(bus.op_commit), 64'd1);
        check("short.err",    64'(bus.op_err),    64'(code == 2'b11));
        if (code == 2'b10) model_q.delete();
        @(negedge clk);
        check("short.ack0", 64'(bus.op_ack), 64'd0);
        check_status("short");
    endtask

    initial begin
        logic [WORD_W-1:0] w;
        int                sel;
        reset_n    = 1'b0;
        bus.val_op = 1'b0;
        bus.op     = 2'b00;
        bus.sdi    = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // 1/2: single word round trip
        do_wr(32'hA5A5_0F0F, 1'b0);
        do_rd();

        // 3: empty read, overfill by one, drain across pointer wrap
        do_rd();
        for (int i = 0; i <= DEPTH; i++) begin
            w = $urandom;
            do_wr(w, ^w);
        end
        for (int i = 0; i < DEPTH; i++) do_rd();
        do_rd();

        // 4: reset at scan bit 10 of a WR with one word already stored
        w = $urandom;
        do_wr(w, ^w);
        bus.val_op = 1'b1;
        bus.op     = 2'b00;
        @(negedge clk);
        bus.val_op = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.sdi = 1'($urandom);
            @(negedge clk);
        end
        reset_n = 1'b0;
        model_q.delete();
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        reset_n = 1'b1;
        w = $urandom;
        do_wr(w, ^w);
        do_rd();

        // 5: clear with five words, then the reserved op
        for (int i = 0; i < 5; i++) begin
            w = $urandom;
            do_wr(w, ^w);
        end
        do_short(2'b10);
        w = $urandom;
        do_wr(w, ^w);
        do_short(2'b11);
        do_rd();

`ifdef SIPO_BUF_PARITY_EN
        // 6: bad parity dropped, good parity stored
        do_wr(32'h0000_0001, 1'b0);
        do_wr(32'h0000_0001, 1'b1);
        do_rd();
`endif

        // Random mix of operations against the queue model
        for (int i = 0; i < 60; i++) begin
            sel = int'($urandom_range(0, 9));
            w   = $urandom;
            if (sel < 5)       do_wr(w, (^w) ^ (PAR_EN && ($urandom_range(0, 7) == 0)));
            else if (sel < 8)  do_rd();
            else if (sel == 8) do_short(2'b10);
            else               do_short(2'b11);
        end
        while (model_q.size() > 0) do_rd();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
